tlb_miss_ctrl: RTL and testbench
================================

Name: tlb_miss_ctrl

Overview:
- Central VM exception sequencer for the multi-cycle CPU with iTLB and dTLB.
- Arbitrates iTLB-miss and dTLB-miss requests and latches the fault context registers rm0/rm1/rm2.
- Sequences pipeline flush and redirect to the supervisor handler, gates TLBWRITE fills to both TLBs, and handles IRET return to user mode with VM enabled.
- Sits beside the fetch and mem stages and drives the CPU's redirect/flush and vm_enable controls.

Parameters:
- BOOT_PC, 32'h00001000, PC the CPU resets to; informational only, the controller starts in supervisor mode.
- HANDLER_PC, 32'h00002000, redirect target on any TLB miss.
- PA_OFFSET, 32'h00001000, value added to the fault VA to form rm2.
- FLUSH_CYCLES, 2, number of DRAIN cycles before the redirect (legal range 1..15).
- CNT_W, 16, width of the saturating miss counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- itlb_miss  in  1  iTLB miss from fetch.
- itlb_va  in  32  faulting fetch VA.
- dtlb_miss  in  1  dTLB miss from mem.
- dtlb_va  in  32  faulting data VA.
- dtlb_pc  in  32  PC of the faulting load/store.
- iret_commit  in  1  IRET committed in mem.
- tlbwrite_commit  in  1  TLBWRITE committed in mem.
- tlbwrite_va  in  32  VA operand of TLBWRITE.
- tlbwrite_pa  in  32  PA operand of TLBWRITE.
- flush  out  1  kill all in-flight instructions.
- redirect_valid  out  1  one-cycle PC load.
- redirect_pc  out  32  PC to load.
- vm_enable  out  1  translation on (user mode).
- supervisor  out  1  supervisor mode.
- rm0  out  32  return PC.
- rm1  out  32  fault VA.
- rm2  out  32  fault VA + PA_OFFSET.
- cause  out  2  01 = iTLB, 10 = dTLB, 00 = none.
- itlb_we, dtlb_we  out  1  TLB fill strobes.
- tlb_wr_va, tlb_wr_pa  out  32  fill data.
- priv_err  out  1  sticky privilege violation.
- itlb_miss_cnt, dtlb_miss_cnt  out  CNT_W  saturating miss counters.

Behaviour:
- States: SUPER, USER, DRAIN, REDIRECT, RET.
- Reset (reset=0, async):
  - state=SUPER, supervisor=1, vm_enable=0.
  - rm0=rm1=rm2=0, cause=0, flush=0, redirect_valid=0, redirect_pc=0.
  - itlb_we=dtlb_we=0, tlb_wr_va=tlb_wr_pa=0, priv_err=0, counters=0.
  - Reset mid-sequence aborts everything; no redirect is issued.
- USER: vm_enable=1, supervisor=0.
  - Miss sampled at edge N: latch rm0/rm1/rm2/cause, increment the matching counter (saturate at all-ones), go to DRAIN.
  - Miss latching: iTLB gives rm0=rm1=itlb_va; dTLB gives rm0=dtlb_pc, rm1=dtlb_va. rm2 = rm1 + PA_OFFSET, 32-bit wrap.
  - Simultaneous iTLB and dTLB miss: dTLB wins (older instruction). Only dtlb_miss_cnt increments; the iTLB miss is dropped and re-occurs after refetch.
- DRAIN:
  - flush=1, supervisor=1, vm_enable=0 from cycle N+1.
  - Lasts exactly FLUSH_CYCLES cycles (down-counter), then REDIRECT.
- REDIRECT: one cycle with flush=1, redirect_valid=1, redirect_pc=HANDLER_PC. Then SUPER.
  - With FLUSH_CYCLES=2: miss at edge N gives redirect_valid high during cycle N+3.
- SUPER:
  - tlbwrite_commit at edge M: itlb_we=dtlb_we=1 for cycle M+1 only, with tlb_wr_va/pa registered from the operands.
  - iret_commit: go to RET.
  - tlbwrite_commit and iret_commit in the same cycle: both honoured; fill strobes and RET coincide.
  - Misses in SUPER are ignored: no latch, no count.
- RET: one cycle with flush=1, redirect_valid=1, redirect_pc=rm0, supervisor=0, vm_enable=1. Then USER.
- In USER, tlbwrite_commit or iret_commit is ignored and sets priv_err=1, which stays set until reset.
- Misses, iret_commit and tlbwrite_commit arriving during DRAIN/REDIRECT/RET are ignored (pipeline is being flushed). rm0..rm2 hold until the next accepted miss.
- redirect_pc holds its last value when redirect_valid=0.

Test Plan:
- Boot: reset released → supervisor=1, vm_enable=0. Then tlbwrite_commit (VA 0x0, PA 0x0) → itlb_we=dtlb_we=1 one cycle with tlb_wr_va=0, tlb_wr_pa=0. Then iret_commit → one-cycle redirect_pc=0x0, vm_enable=1.
- iTLB miss: in USER, itlb_miss with itlb_va=0x2000 → rm0=rm1=0x2000, rm2=0x3000, cause=01. flush high for 3 cycles; redirect_pc=0x2000 exactly 3 cycles after the sampling edge.
- dTLB miss: in USER, dtlb_miss with va=0x1800, pc=0x2004 → rm1=0x1800, rm2=0x2800, rm0=0x2004, dtlb_miss_cnt=1. Handler TLBWRITE then IRET → redirect_pc=0x2004.
- Simultaneous itlb_miss (va 0x4000) and dtlb_miss (va 0x1804, pc 0x2008) → cause=10, rm1=0x1804, itlb_miss_cnt unchanged.
- Privilege: iret_commit and tlbwrite_commit in USER → no redirect, no *_we, priv_err=1 and stays 1. rm2 wrap check: va=0xFFFFF800 → rm2=0x00000800.
- Reset asserted during DRAIN → all outputs take reset values immediately (async); no redirect_valid after release. Counter saturation: CNT_W=4, 20 iTLB misses → itlb_miss_cnt=4'hF.

Source files
------------

// File: rtl/tlb_miss_ctrl.sv
// VM exception sequencer: arbitrates iTLB/dTLB misses, latches fault context,
// drives flush/redirect to the supervisor handler, gates TLB fills and IRET.
module tlb_miss_ctrl #(
    parameter logic [31:0] BOOT_PC      = 32'h00001000,
    parameter logic [31:0] HANDLER_PC   = 32'h00002000,
    parameter logic [31:0] PA_OFFSET    = 32'h00001000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             itlb_miss,
    input  logic [31:0]      itlb_va,
    input  logic             dtlb_miss,
    input  logic [31:0]      dtlb_va,
    input  logic [31:0]      dtlb_pc,
    input  logic             iret_commit,
    input  logic             tlbwrite_commit,
    input  logic [31:0]      tlbwrite_va,
    input  logic [31:0]      tlbwrite_pa,
    output logic             flush,
    output logic             redirect_valid,
    output logic [31:0]      redirect_pc,
    output logic             vm_enable,
    output logic             supervisor,
    output logic [31:0]      rm0,
    output logic [31:0]      rm1,
    output logic [31:0]      rm2,
    output logic [1:0]       cause,
    output logic             itlb_we,
    output logic             dtlb_we,
    output logic [31:0]      tlb_wr_va,
    output logic [31:0]      tlb_wr_pa,
    output logic             priv_err,
    output logic [CNT_W-1:0] itlb_miss_cnt,
    output logic [CNT_W-1:0] dtlb_miss_cnt
);

    localparam int unsigned DRAIN_W = 4;

    // Drain length must fit the down-counter; boot PC must be word aligned
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || BOOT_PC[1:0] != 2'b00) begin : g_bad_param
        $error("tlb_miss_ctrl: illegal FLUSH_CYCLES or unaligned BOOT_PC");
    end

    typedef enum logic [2:0] {
        ST_SUPER    = 3'd0,
        ST_USER     = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_RET      = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DRAIN_W-1:0] drain_cnt;

    logic               miss_take;
    logic               fill_take;
    logic               priv_viol;
    logic               flush_nxt;
    logic               redirect_valid_nxt;
    logic [31:0]        redirect_pc_nxt;
    logic               vm_enable_nxt;
    logic               supervisor_nxt;
    logic [31:0]        rm0_nxt;
    logic [31:0]        rm1_nxt;
    logic [1:0]         cause_nxt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_SUPER;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_SUPER:    if (iret_commit) state_nxt = ST_RET;
            ST_USER:     if (itlb_miss || dtlb_miss) state_nxt = ST_DRAIN;
            ST_DRAIN:    if (drain_cnt == '0) state_nxt = ST_REDIRECT;
            ST_REDIRECT: state_nxt = ST_SUPER;
            ST_RET:      state_nxt = ST_USER;
            default:     state_nxt = ST_SUPER;
        endcase
    end

    // Output decode: next values for the registered outputs and datapath
    always_comb begin
        miss_take          = (state == ST_USER) && (itlb_miss || dtlb_miss);
        fill_take          = (state == ST_SUPER) && tlbwrite_commit;
        priv_viol          = (state == ST_USER) && (iret_commit || tlbwrite_commit);
        flush_nxt          = state_nxt inside {ST_DRAIN, ST_REDIRECT, ST_RET};
        redirect_valid_nxt = state_nxt inside {ST_REDIRECT, ST_RET};
        vm_enable_nxt      = state_nxt inside {ST_USER, ST_RET};
        supervisor_nxt     = !vm_enable_nxt;
        redirect_pc_nxt    = redirect_pc;
        if (state_nxt == ST_REDIRECT) redirect_pc_nxt = HANDLER_PC;
        else if (state_nxt == ST_RET) redirect_pc_nxt = rm0;
        // dTLB has priority: it belongs to the older instruction
        rm0_nxt   = dtlb_miss ? dtlb_pc : itlb_va;
        rm1_nxt   = dtlb_miss ? dtlb_va : itlb_va;
        cause_nxt = dtlb_miss ? 2'b10 : 2'b01;
    end

    // Registered outputs, fault context, fill port, drain counter and miss counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= '0;
            vm_enable      <= 1'b0;
            supervisor     <= 1'b1;
            rm0            <= '0;
            rm1            <= '0;
            rm2            <= '0;
            cause          <= 2'b00;
            itlb_we        <= 1'b0;
            dtlb_we        <= 1'b0;
            tlb_wr_va      <= '0;
            tlb_wr_pa      <= '0;
            priv_err       <= 1'b0;
            itlb_miss_cnt  <= '0;
            dtlb_miss_cnt  <= '0;
            drain_cnt      <= '0;
        end else begin
            flush          <= flush_nxt;
            redirect_valid <= redirect_valid_nxt;
            redirect_pc    <= redirect_pc_nxt;
            vm_enable      <= vm_enable_nxt;
            supervisor     <= supervisor_nxt;
            itlb_we        <= fill_take;
            dtlb_we        <= fill_take;
            if (fill_take) begin
                tlb_wr_va <= tlbwrite_va;
                tlb_wr_pa <= tlbwrite_pa;
            end
            if (priv_viol) priv_err <= 1'b1;
            if (miss_take) begin
                rm0       <= rm0_nxt;
                rm1       <= rm1_nxt;
                rm2       <= rm1_nxt + PA_OFFSET;
                cause     <= cause_nxt;
                drain_cnt <= DRAIN_W'(FLUSH_CYCLES - 1);
                if (dtlb_miss) begin
                    if (dtlb_miss_cnt != '1) dtlb_miss_cnt <= dtlb_miss_cnt + CNT_W'(1);
                end else begin
                    if (itlb_miss_cnt != '1) itlb_miss_cnt <= itlb_miss_cnt + CNT_W'(1);
                end
            end else if (state == ST_DRAIN && drain_cnt != '0) begin
                drain_cnt <= drain_cnt - DRAIN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tlb_miss_ctrl.sv
// Directed self-checking bench for tlb_miss_ctrl (counters narrowed to 4 bits).
module tb_tlb_miss_ctrl;

    localparam int unsigned CNT_W = 4;
    localparam logic [31:0] HPC   = 32'h00002000;

    logic             clk = 1'b0;
    logic             reset;
    logic             itlb_miss, dtlb_miss, iret_commit, tlbwrite_commit;
    logic [31:0]      itlb_va, dtlb_va, dtlb_pc, tlbwrite_va, tlbwrite_pa;
    logic             flush, redirect_valid, vm_enable, supervisor;
    logic [31:0]      redirect_pc, rm0, rm1, rm2, tlb_wr_va, tlb_wr_pa;
    logic [1:0]       cause;
    logic             itlb_we, dtlb_we, priv_err;
    logic [CNT_W-1:0] itlb_miss_cnt, dtlb_miss_cnt;

    int n_chk = 0;
    int n_bad = 0;

    tlb_miss_ctrl #(
        .BOOT_PC(32'h00001000), .HANDLER_PC(HPC), .PA_OFFSET(32'h00001000),
        .FLUSH_CYCLES(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .itlb_miss(itlb_miss), .itlb_va(itlb_va),
        .dtlb_miss(dtlb_miss), .dtlb_va(dtlb_va), .dtlb_pc(dtlb_pc),
        .iret_commit(iret_commit), .tlbwrite_commit(tlbwrite_commit),
        .tlbwrite_va(tlbwrite_va), .tlbwrite_pa(tlbwrite_pa),
        .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .vm_enable(vm_enable), .supervisor(supervisor),
        .rm0(rm0), .rm1(rm1), .rm2(rm2), .cause(cause),
        .itlb_we(itlb_we), .dtlb_we(dtlb_we),
        .tlb_wr_va(tlb_wr_va), .tlb_wr_pa(tlb_wr_pa),
        .priv_err(priv_err),
        .itlb_miss_cnt(itlb_miss_cnt), .dtlb_miss_cnt(dtlb_miss_cnt)
    );

    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a miss for one edge, then follow the drain/redirect walk into SUPER
    task automatic miss_seq(input logic im, input logic dm, input logic [31:0] iva,
                            input logic [31:0] dva, input logic [31:0] dpc);
        itlb_miss = im; itlb_va = iva; dtlb_miss = dm; dtlb_va = dva; dtlb_pc = dpc;
        tick();
        itlb_miss = 1'b0; dtlb_miss = 1'b0;
        chk("drain1_flush", flush, 1);
        chk("drain1_sup", supervisor, 1);
        chk("drain1_vm", vm_enable, 0);
        chk("drain1_rv", redirect_valid, 0);
        iret_commit = 1'b1; itlb_miss = 1'b1;
        tick();
        iret_commit = 1'b0; itlb_miss = 1'b0;
        chk("drain2_flush", flush, 1);
        chk("drain2_rv", redirect_valid, 0);
        tick();
        chk("redir_flush", flush, 1);
        chk("redir_rv", redirect_valid, 1);
        chk("redir_pc", redirect_pc, HPC);
        tick();
        chk("super_flush", flush, 0);
        chk("super_rv", redirect_valid, 0);
        chk("super_sup", supervisor, 1);
    endtask

    // IRET from SUPER: one RET cycle redirecting to rm0, then USER
    task automatic do_iret(input logic [31:0] exp_pc);
        iret_commit = 1'b1;
        tick();
        iret_commit = 1'b0;
        chk("ret_rv", redirect_valid, 1);
        chk("ret_pc", redirect_pc, exp_pc);
        chk("ret_flush", flush, 1);
        chk("ret_vm", vm_enable, 1);
        chk("ret_sup", supervisor, 0);
        tick();
        chk("user_rv", redirect_valid, 0);
        chk("user_flush", flush, 0);
        chk("user_vm", vm_enable, 1);
    endtask

    // One TLBWRITE in SUPER: strobes for exactly one cycle with the operands
    task automatic do_fill(input logic [31:0] va, input logic [31:0] pa);
        tlbwrite_commit = 1'b1; tlbwrite_va = va; tlbwrite_pa = pa;
        tick();
        tlbwrite_commit = 1'b0;
        chk("fill_iwe", itlb_we, 1);
        chk("fill_dwe", dtlb_we, 1);
        chk("fill_va", tlb_wr_va, va);
        chk("fill_pa", tlb_wr_pa, pa);
        tick();
        chk("fill_iwe_off", itlb_we, 0);
        chk("fill_dwe_off", dtlb_we, 0);
    endtask

    initial begin
        logic seen;
        reset = 1'b0;
        itlb_miss = 1'b0; dtlb_miss = 1'b0; iret_commit = 1'b0; tlbwrite_commit = 1'b0;
        itlb_va = '0; dtlb_va = '0; dtlb_pc = '0; tlbwrite_va = '0; tlbwrite_pa = '0;
        tick(); tick();
        chk("rst_sup", supervisor, 1);
        chk("rst_vm", vm_enable, 0);
        chk("rst_flush", flush, 0);
        chk("rst_rpc", redirect_pc, 0);
        chk("rst_cause", cause, 0);
        reset = 1'b1;
        tick();
        chk("boot_sup", supervisor, 1);
        chk("boot_vm", vm_enable, 0);

        // Boot: identity fill of page 0, then IRET to PC 0
        do_fill(32'h0, 32'h0);
        do_iret(32'h0);

        // iTLB miss
        miss_seq(1'b1, 1'b0, 32'h00002000, 32'h0, 32'h0);
        chk("im_rm0", rm0, 32'h00002000);
        chk("im_rm1", rm1, 32'h00002000);
        chk("im_rm2", rm2, 32'h00003000);
        chk("im_cause", cause, 2'b01);
        chk("im_icnt", itlb_miss_cnt, 1);
        chk("im_dcnt", dtlb_miss_cnt, 0);
        do_iret(32'h00002000);

        // dTLB miss, handler fill, IRET back to faulting PC
        miss_seq(1'b0, 1'b1, 32'h0, 32'h00001800, 32'h00002004);
        chk("dm_rm0", rm0, 32'h00002004);
        chk("dm_rm1", rm1, 32'h00001800);
        chk("dm_rm2", rm2, 32'h00002800);
        chk("dm_cause", cause, 2'b10);
        chk("dm_dcnt", dtlb_miss_cnt, 1);
        do_fill(32'h00001000, 32'h00005000);
        do_iret(32'h00002004);

        // Simultaneous misses: dTLB wins
        miss_seq(1'b1, 1'b1, 32'h00004000, 32'h00001804, 32'h00002008);
        chk("sim_cause", cause, 2'b10);
        chk("sim_rm1", rm1, 32'h00001804);
        chk("sim_rm0", rm0, 32'h00002008);
        chk("sim_icnt", itlb_miss_cnt, 1);
        chk("sim_dcnt", dtlb_miss_cnt, 2);
        do_iret(32'h00002008);

        // Privileged ops from USER are ignored and flag priv_err
        iret_commit = 1'b1; tlbwrite_commit = 1'b1; tlbwrite_va = 32'hAAAA; tlbwrite_pa = 32'hBBBB;
        tick();
        iret_commit = 1'b0; tlbwrite_commit = 1'b0;
        chk("priv_rv", redirect_valid, 0);
        chk("priv_iwe", itlb_we, 0);
        chk("priv_dwe", dtlb_we, 0);
        chk("priv_err", priv_err, 1);
        chk("priv_vm", vm_enable, 1);
        tick(); tick();
        chk("priv_sticky", priv_err, 1);
        chk("priv_wrva", tlb_wr_va, 32'h00001000);

        // rm2 wraps at 32 bits
        miss_seq(1'b1, 1'b0, 32'hFFFFF800, 32'h0, 32'h0);
        chk("wrap_rm2", rm2, 32'h00000800);
        chk("wrap_icnt", itlb_miss_cnt, 2);
        do_iret(32'hFFFFF800);

        // 18 more iTLB misses: 20 total saturates a 4-bit counter
        for (int i = 0; i < 18; i++) begin
            miss_seq(1'b1, 1'b0, 32'h00010000 + 32'(i * 4096), 32'h0, 32'h0);
            do_iret(32'h00010000 + 32'(i * 4096));
        end
        chk("sat_icnt", itlb_miss_cnt, 4'hF);
        chk("sat_dcnt", dtlb_miss_cnt, 2);
        chk("sat_priv", priv_err, 1);

        // Reset during DRAIN: immediate clear, no redirect afterwards
        itlb_miss = 1'b1; itlb_va = 32'h00007000;
        tick();
        itlb_miss = 1'b0;
        chk("pre_rst_flush", flush, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_flush", flush, 0);
        chk("arst_sup", supervisor, 1);
        chk("arst_vm", vm_enable, 0);
        chk("arst_rm0", rm0, 0);
        chk("arst_icnt", itlb_miss_cnt, 0);
        chk("arst_priv", priv_err, 0);
        #2 reset = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (redirect_valid || flush) seen = 1'b1;
        end
        chk("no_redir_after_rst", seen, 0);
        chk("post_rst_sup", supervisor, 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
